hdc_classify_ctrl: RTL and testbench

HDC_CLASSIFY_CTRL -- requirements
Module: hdc_classify_ctrl

---
 rtl/hdc_pkg.sv | 34 +++
 rtl/hdc_classify_ctrl_if.sv | 39 +++
 rtl/hdc_addr_cnt.sv | 49 ++++
 rtl/hdc_classify_ctrl.sv | 131 +++++++++++++
 tb/tb_hdc_classify_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/hdc_pkg.sv
// Purpose: shared defaults, FSM state encoding and result codes for the HDC classifier controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hdc_pkg;

    localparam int DIM_DEF        = 10000;
    localparam int MAX_LENGTH_DEF = 200;
    localparam int CNT_W_DEF      = 32;

    // Address widths are fixed by the datapath: 14 bits covers DIM up to 16383,
    // 8 bits covers any message length that fits the length port.
    localparam int DIM_AW  = 14;
    localparam int CHAR_AW = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_AVG,
        ST_THRESH,
        ST_COMPARE,
        ST_DONE
    } state_t;

    localparam logic signed [1:0] RES_SPAM = 2'sb00;
    localparam logic signed [1:0] RES_HAM  = 2'sb01;
    localparam logic signed [1:0] RES_NONE = 2'sb11;

    function automatic logic [CHAR_AW-1:0] clamp_len(input logic [CHAR_AW-1:0] len,
                                                     input logic [CHAR_AW-1:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/hdc_classify_ctrl_if.sv
// Purpose: bundles the request/result handshake and the datapath strobe/address bus.
// Latency: n/a (wires only).
// Backpressure: none; start is a one-cycle request that is dropped while busy.
//   master: host + datapath side (drives start/length and the Hamming counts)
//   slave : the classifier controller (drives busy/done/result, addresses and strobes)
interface hdc_classify_ctrl_if #(
    parameter int CNT_W = hdc_pkg::CNT_W_DEF
) ();
    import hdc_pkg::*;

    logic                    start;
    logic [CHAR_AW-1:0]      length;
    logic                    busy;
    logic                    done;
    logic signed [1:0]       result;
    logic [CHAR_AW-1:0]      char_addr;
    logic [DIM_AW-1:0]       dim_addr;
    logic                    acc_clr;
    logic                    acc_en;
    logic                    avg_en;
    logic                    thr_en;
    logic                    cmp_en;
    logic                    cnt_clr;
    logic [CNT_W-1:0]        count_ham;
    logic [CNT_W-1:0]        count_spam;

    modport master (
        output start, length, count_ham, count_spam,
        input  busy, done, result, char_addr, dim_addr,
               acc_clr, acc_en, avg_en, thr_en, cmp_en, cnt_clr
    );

    modport slave (
        input  start, length, count_ham, count_spam,
        output busy, done, result, char_addr, dim_addr,
               acc_clr, acc_en, avg_en, thr_en, cmp_en, cnt_clr
    );

endinterface

// File: rtl/hdc_addr_cnt.sv
// Purpose: nested wrap counter; dim_addr is the inner index, char_addr the outer one.
// Latency: addresses are registers; dim_last/last are decoded from them in the same cycle.
// Backpressure: advances only when en is high; outer index moves only when outer_en is also high.
//   ports: clk, reset, clr (sync zero), en, outer_en, len (outer limit),
//          dim_addr, char_addr, dim_last (inner at DIM-1), last (both at their final value)
module hdc_addr_cnt
    import hdc_pkg::*;
#(
    parameter int DIM = DIM_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    input  logic               outer_en,
    input  logic [CHAR_AW-1:0] len,
    output logic [DIM_AW-1:0]  dim_addr,
    output logic [CHAR_AW-1:0] char_addr,
    output logic               dim_last,
    output logic               last
);

    localparam logic [DIM_AW-1:0] DIM_MAX = DIM_AW'(DIM - 1);

    logic char_last;

    assign dim_last  = (dim_addr == DIM_MAX);
    // len==0 never reaches the outer counter (the FSM skips ACCUM), so the
    // underflow of len-1 is harmless.
    assign char_last = (char_addr == (len - CHAR_AW'(1)));
    assign last      = dim_last && char_last;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            dim_addr  <= '0;
            char_addr <= '0;
        end else if (en) begin
            if (dim_last) begin
                dim_addr <= '0;
                if (outer_en) begin
                    char_addr <= char_last ? '0 : char_addr + CHAR_AW'(1);
                end
            end else begin
                dim_addr <= dim_addr + DIM_AW'(1);
            end
        end
    end

endmodule

// File: rtl/hdc_classify_ctrl.sv
// Purpose: sequences clear/accumulate/average/threshold/compare for one HDC message classification.
// Latency: start to done = 3*DIM + len*DIM + 2 cycles (DIM + 1 when len is 0); all outputs registered.
// Backpressure: none; start is only accepted in IDLE, requests while busy are dropped.
//   ports: clk, reset (sync, active-high), bus (slave modport: start/length in,
//          busy/done/result out, char_addr/dim_addr + strobes to datapath, Hamming counts in)
module hdc_classify_ctrl
    import hdc_pkg::*;
#(
    parameter int MAX_LENGTH = MAX_LENGTH_DEF,
    parameter int DIM        = DIM_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    hdc_classify_ctrl_if.slave bus
);

    state_t             state_q, state_d;
    logic [CHAR_AW-1:0] len_q;
    logic [CNT_W-1:0]   count_ham, count_spam;

    logic cnt_en, cnt_outer_en, cnt_idle_clr;
    logic dim_last, seq_last;
    logic [DIM_AW-1:0]  dim_addr;
    logic [CHAR_AW-1:0] char_addr;

    logic busy_d, done_d, acc_clr_d, acc_en_d, avg_en_d, thr_en_d, cmp_en_d;
    logic busy_q, done_q, acc_clr_q, acc_en_q, avg_en_q, thr_en_q, cmp_en_q;
    logic signed [1:0] result_d, result_q;

    assign count_ham  = bus.count_ham;
    assign count_spam = bus.count_spam;

    // Counter walks only in the DIM-long phases; the outer (character) index
    // moves only while accumulating so every phase starts at address 0.
    assign cnt_en       = (state_q == ST_CLEAR)  || (state_q == ST_ACCUM) ||
                          (state_q == ST_THRESH) || (state_q == ST_COMPARE);
    assign cnt_outer_en = (state_q == ST_ACCUM);
    assign cnt_idle_clr = (state_q == ST_IDLE);

    hdc_addr_cnt #(
        .DIM (DIM)
    ) u_addr_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr       (cnt_idle_clr),
        .en        (cnt_en),
        .outer_en  (cnt_outer_en),
        .len       (len_q),
        .dim_addr  (dim_addr),
        .char_addr (char_addr),
        .dim_last  (dim_last),
        .last      (seq_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (bus.start) state_d = ST_CLEAR;
            ST_CLEAR:   if (dim_last)  state_d = (len_q == '0) ? ST_DONE : ST_ACCUM;
            ST_ACCUM:   if (seq_last)  state_d = ST_AVG;
            ST_AVG:                    state_d = ST_THRESH;
            ST_THRESH:  if (dim_last)  state_d = ST_COMPARE;
            ST_COMPARE: if (dim_last)  state_d = ST_DONE;
            ST_DONE:                   state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so they line
        // up cycle-for-cycle with state_q and with the counter addresses.
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        acc_clr_d = (state_d == ST_CLEAR);
        acc_en_d  = (state_d == ST_ACCUM);
        avg_en_d  = (state_d == ST_AVG);
        thr_en_d  = (state_d == ST_THRESH);
        cmp_en_d  = (state_d == ST_COMPARE);

        // A larger distance to the ham reference means the message is spam.
        result_d = RES_NONE;
        if (len_q != '0) begin
            if (count_ham > count_spam)      result_d = RES_SPAM;
            else if (count_ham < count_spam) result_d = RES_HAM;
            else                             result_d = RES_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            acc_clr_q <= 1'b0;
            acc_en_q  <= 1'b0;
            avg_en_q  <= 1'b0;
            thr_en_q  <= 1'b0;
            cmp_en_q  <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            acc_clr_q <= acc_clr_d;
            acc_en_q  <= acc_en_d;
            avg_en_q  <= avg_en_d;
            thr_en_q  <= thr_en_d;
            cmp_en_q  <= cmp_en_d;
            if (state_q == ST_IDLE && bus.start) begin
                len_q <= clamp_len(bus.length, CHAR_AW'(MAX_LENGTH));
            end
            // Captured on entry to DONE so result is valid alongside done.
            if (state_d == ST_DONE) begin
                result_q <= result_d;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.dim_addr  = dim_addr;
    assign bus.char_addr = char_addr;
    assign bus.acc_clr   = acc_clr_q;
    assign bus.cnt_clr   = acc_clr_q;
    assign bus.acc_en    = acc_en_q;
    assign bus.avg_en    = avg_en_q;
    assign bus.thr_en    = thr_en_q;
    assign bus.cmp_en    = cmp_en_q;

endmodule

// File: tb/tb_hdc_classify_ctrl.sv
// Purpose: directed checks of hdc_classify_ctrl with DIM=8, MAX_LENGTH=4.
// Latency: expected start-to-done cycle counts are hand-computed per scenario.
// Backpressure: start pulses during a run must be dropped.
module tb_hdc_classify_ctrl;
    import hdc_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hdc_classify_ctrl_if #(.CNT_W(32)) bus ();

    hdc_classify_ctrl #(
        .MAX_LENGTH (4),
        .DIM        (8),
        .CNT_W      (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Per-run observations filled by run_op.
    int lat, n_clr, n_cnt_clr, n_acc, n_avg, n_thr, n_cmp, n_addr_bad, n_strobe_bad;

    // Pulses start with the given length and observes every cycle until done
    // (cycle 1 = first cycle after the start edge). lat stays -1 on timeout.
    task automatic run_op(input logic [7:0] len, input int restart_at);
        lat = -1; n_clr = 0; n_cnt_clr = 0; n_acc = 0; n_avg = 0;
        n_thr = 0; n_cmp = 0; n_addr_bad = 0; n_strobe_bad = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.length = len;
        @(negedge clk);
        bus.start  = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            int s;
            s = int'(bus.acc_clr) + int'(bus.acc_en) + int'(bus.avg_en) +
                int'(bus.thr_en) + int'(bus.cmp_en);
            if (s > 1) n_strobe_bad++;
            if (bus.acc_clr) begin
                if (bus.dim_addr != 14'(n_clr % 8) || bus.char_addr != 8'd0) n_addr_bad++;
                n_clr++;
            end
            if (bus.cnt_clr) n_cnt_clr++;
            if (bus.acc_en) begin
                if (bus.dim_addr != 14'(n_acc % 8) || bus.char_addr != 8'(n_acc / 8)) n_addr_bad++;
                n_acc++;
            end
            if (bus.avg_en) n_avg++;
            if (bus.thr_en) begin
                if (bus.dim_addr != 14'(n_thr % 8)) n_addr_bad++;
                n_thr++;
            end
            if (bus.cmp_en) begin
                if (bus.dim_addr != 14'(n_cmp % 8)) n_addr_bad++;
                n_cmp++;
            end
            if (!bus.busy) n_strobe_bad++;
            if (bus.done) begin
                if (s != 0 || bus.cnt_clr) n_strobe_bad++;
                lat = k;
                break;
            end
            bus.start = (k == restart_at);
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.length = 8'd0;
        bus.count_ham = 32'd0;
        bus.count_spam = 32'd0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.result !== 2'sb00) begin errors++; $display("FAIL reset_result got %0d want 0", bus.result); end
        checks++; if (bus.dim_addr !== 14'd0 || bus.char_addr !== 8'd0) begin
            errors++; $display("FAIL reset_addr got dim %0d char %0d want 0 0", bus.dim_addr, bus.char_addr); end
        checks++; if ({bus.acc_clr, bus.acc_en, bus.avg_en, bus.thr_en, bus.cmp_en, bus.cnt_clr} !== 6'b0) begin
            errors++; $display("FAIL reset_strobes got %b want 000000",
                {bus.acc_clr, bus.acc_en, bus.avg_en, bus.thr_en, bus.cmp_en, bus.cnt_clr}); end
        // Reset wins over a simultaneous start.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_vs_start got busy %b want 0", bus.busy); end
    endtask

    task automatic test_basic();
        bus.count_ham = 32'd5;
        bus.count_spam = 32'd9;
        run_op(8'd3, -1);
        checks++; if (lat != 50) begin errors++; $display("FAIL basic_latency got %0d want 50", lat); end
        checks++; if (n_acc != 24) begin errors++; $display("FAIL basic_acc_en got %0d want 24", n_acc); end
        checks++; if (n_clr != 8 || n_cnt_clr != 8) begin
            errors++; $display("FAIL basic_clear got acc_clr %0d cnt_clr %0d want 8 8", n_clr, n_cnt_clr); end
        checks++; if (n_avg != 1) begin errors++; $display("FAIL basic_avg got %0d want 1", n_avg); end
        checks++; if (n_thr != 8 || n_cmp != 8) begin
            errors++; $display("FAIL basic_thr_cmp got %0d %0d want 8 8", n_thr, n_cmp); end
        checks++; if (n_addr_bad != 0) begin errors++; $display("FAIL basic_addr got %0d bad want 0", n_addr_bad); end
        checks++; if (n_strobe_bad != 0) begin errors++; $display("FAIL basic_strobes got %0d bad want 0", n_strobe_bad); end
        checks++; if (bus.result !== 2'sb01) begin errors++; $display("FAIL basic_result got %0d want 1", bus.result); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL basic_after_done got done %b busy %b want 0 0", bus.done, bus.busy); end
        checks++; if (bus.result !== 2'sb01) begin errors++; $display("FAIL basic_result_hold got %0d want 1", bus.result); end
    endtask

    task automatic test_compare();
        logic [31:0]       ham_v [4];
        logic [31:0]       spam_v[4];
        logic signed [1:0] exp_v [4];
        ham_v = '{32'd9, 32'd7, 32'd0, 32'd5};
        spam_v = '{32'd5, 32'd7, 32'hFFFF_FFFF, 32'd9};
        exp_v = '{2'sb00, 2'sb11, 2'sb01, 2'sb01};
        for (int i = 0; i < 4; i++) begin
            bus.count_ham = ham_v[i];
            bus.count_spam = spam_v[i];
            run_op(8'd1, -1);
            checks++; if (lat != 34) begin errors++; $display("FAIL cmp%0d_latency got %0d want 34", i, lat); end
            checks++; if (bus.result !== exp_v[i]) begin
                errors++; $display("FAIL cmp%0d_result got %0d want %0d", i, bus.result, exp_v[i]); end
        end
    endtask

    task automatic test_zero_len();
        bus.count_ham = 32'd5;
        bus.count_spam = 32'd9;
        run_op(8'd0, -1);
        checks++; if (lat != 9) begin errors++; $display("FAIL zero_latency got %0d want 9", lat); end
        checks++; if (n_clr != 8) begin errors++; $display("FAIL zero_acc_clr got %0d want 8", n_clr); end
        checks++; if (n_acc + n_thr + n_cmp + n_avg != 0) begin
            errors++; $display("FAIL zero_no_strobes got acc %0d thr %0d cmp %0d avg %0d want 0", n_acc, n_thr, n_cmp, n_avg); end
        checks++; if (bus.result !== 2'sb11) begin errors++; $display("FAIL zero_result got %0d want -1", bus.result); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int extra_done;
        bus.count_ham = 32'd9;
        bus.count_spam = 32'd5;
        run_op(8'd3, 20);
        checks++; if (lat != 50) begin errors++; $display("FAIL ignored_start_latency got %0d want 50", lat); end
        checks++; if (n_acc != 24) begin errors++; $display("FAIL ignored_start_acc got %0d want 24", n_acc); end
        checks++; if (bus.result !== 2'sb00) begin errors++; $display("FAIL ignored_start_result got %0d want 0", bus.result); end
        extra_done = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra_done++;
        end
        checks++; if (extra_done != 0) begin errors++; $display("FAIL ignored_start_queued got %0d busy/done cycles want 0", extra_done); end
    endtask

    task automatic test_clamp();
        logic [7:0] len_v[3];
        len_v = '{8'd255, 8'd5, 8'd4};
        bus.count_ham = 32'd5;
        bus.count_spam = 32'd9;
        for (int i = 0; i < 3; i++) begin
            run_op(len_v[i], -1);
            checks++; if (n_acc != 32) begin errors++; $display("FAIL clamp%0d_acc got %0d want 32", i, n_acc); end
            checks++; if (lat != 58) begin errors++; $display("FAIL clamp%0d_latency got %0d want 58", i, lat); end
            checks++; if (n_addr_bad != 0) begin errors++; $display("FAIL clamp%0d_addr got %0d bad want 0", i, n_addr_bad); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int seen, late_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.length = 8'd2;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            if (bus.thr_en) begin seen = 1; break; end
            @(negedge clk);
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL midreset_reach_thresh got %0d want 1", seen); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL midreset_busy_done got %b %b want 0 0", bus.busy, bus.done); end
        checks++; if ({bus.acc_clr, bus.acc_en, bus.avg_en, bus.thr_en, bus.cmp_en, bus.cnt_clr} !== 6'b0) begin
            errors++; $display("FAIL midreset_strobes got %b want 000000",
                {bus.acc_clr, bus.acc_en, bus.avg_en, bus.thr_en, bus.cmp_en, bus.cnt_clr}); end
        checks++; if (bus.result !== 2'sb00) begin errors++; $display("FAIL midreset_result got %0d want 0", bus.result); end
        checks++; if (bus.dim_addr !== 14'd0 || bus.char_addr !== 8'd0) begin
            errors++; $display("FAIL midreset_addr got %0d %0d want 0 0", bus.dim_addr, bus.char_addr); end
        late_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) late_done++;
        end
        checks++; if (late_done != 0) begin errors++; $display("FAIL midreset_no_done got %0d want 0", late_done); end
        bus.count_ham = 32'd7;
        bus.count_spam = 32'd7;
        run_op(8'd2, -1);
        checks++; if (lat != 42) begin errors++; $display("FAIL midreset_rerun_latency got %0d want 42", lat); end
        checks++; if (n_acc != 16) begin errors++; $display("FAIL midreset_rerun_acc got %0d want 16", n_acc); end
        checks++; if (bus.result !== 2'sb11) begin errors++; $display("FAIL midreset_rerun_result got %0d want -1", bus.result); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_compare();
        test_zero_len();
        test_back_to_back();
        test_clamp();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
